// File: rtl/anita3_readout_pkg.sv
// Shared definitions for the ANITA3 readout sequencer: FSM encoding,
// event header field layout and HOLD buffer geometry.
package anita3_readout_pkg;

  localparam int HOLD_BUFFERS = 4;
  localparam int BUF_W        = 2;
  localparam int SRC_W        = 4;
  localparam int REQ_W        = BUF_W + SRC_W;
  localparam int EVT_NUM_W    = 16;
  localparam int HDR_W        = 24;

  // Header layout: {event_number[15:0], timeout_flag, 1'b0, buffer[1:0], source[3:0]}.
  // Bit 6 is reserved and always zero.
  localparam int HDR_SRC_LSB  = 0;
  localparam int HDR_BUF_LSB  = 4;
  localparam int HDR_TMO_BIT  = 7;
  localparam int HDR_EVT_LSB  = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT_DIG = 3'd2,
    ST_HEADER   = 3'd3,
    ST_CLEAR    = 3'd4
  } seq_state_e;

  function automatic logic [HDR_W-1:0] build_header(
    input logic [EVT_NUM_W-1:0] evt_num,
    input logic                 timeout_flag,
    input logic [BUF_W-1:0]     buf_idx,
    input logic [SRC_W-1:0]     src
  );
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_EVT_LSB +: EVT_NUM_W] = evt_num;
    h[HDR_TMO_BIT]              = timeout_flag;
    h[HDR_BUF_LSB +: BUF_W]     = buf_idx;
    h[HDR_SRC_LSB +: SRC_W]     = src;
    return h;
  endfunction

endpackage

// File: rtl/anita3_readout_fifo.sv
// Synchronous FIFO holding pending digitize requests. A push on a full
// queue is taken only when a pop happens in the same cycle. DEPTH >= 2.
module anita3_readout_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // Pointers wrap explicitly so non-power-of-two depths still work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  // Next pointer, occupancy and storage contents.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read when counted valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/anita3_readout_sequencer.sv
// Readout sequencer: queues digitize requests from the buffer manager,
// drives one digitization per request, presents an event header to the
// event builder and releases the HOLD buffer afterwards.
//
// Handshake: evt_header_o is held stable while evt_valid_o is high; the
// header is consumed on the cycle where evt_valid_o && evt_ready_i.
module anita3_readout_sequencer
  import anita3_readout_pkg::*;
#(
  parameter int DIG_TIMEOUT = 4095,
  parameter int FIFO_DEPTH  = HOLD_BUFFERS
) (
  input  logic             clk250_i,
  input  logic             rst_i,
  input  logic             digitize_i,
  input  logic [BUF_W-1:0] digitize_buffer_i,
  input  logic [SRC_W-1:0] digitize_source_i,
  output logic             dig_start_o,
  output logic [BUF_W-1:0] dig_buffer_o,
  input  logic             dig_done_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [HDR_W-1:0] evt_header_o,
  output logic             clear_o,
  output logic [BUF_W-1:0] clear_buffer_o,
  output logic             busy_o,
  output logic             overflow_o
);

  localparam int              CNT_W       = $clog2(DIG_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(DIG_TIMEOUT);

  seq_state_e           state_q, state_d;
  logic                 dig_lvl_q, dig_lvl_d;
  logic                 ovf_q, ovf_d;
  logic [BUF_W-1:0]     wbuf_q, wbuf_d;
  logic [SRC_W-1:0]     wsrc_q, wsrc_d;
  logic                 tmo_q, tmo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [EVT_NUM_W-1:0] evt_num_q, evt_num_d;

  logic                              req_push;
  logic                              q_pop, q_full, q_empty;
  logic [REQ_W-1:0]                  q_head;
  logic [$clog2(FIFO_DEPTH+1)-1:0]   q_count;
  logic                              unused_q_count;

  // A request is the rising edge of the digitize level.
  assign req_push = digitize_i & ~dig_lvl_q;

  anita3_readout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk_i   (clk250_i),
    .rst_i   (rst_i),
    .push_i  (req_push),
    .data_i  ({digitize_buffer_i, digitize_source_i}),
    .pop_i   (q_pop),
    .head_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  // Occupancy is not needed by the sequencer itself.
  assign unused_q_count = ^q_count;

  // Edge register and sticky overflow on a dropped request.
  always_comb begin
    dig_lvl_d = digitize_i;
    ovf_d     = ovf_q | (req_push & q_full & ~q_pop);
  end

  // Sequencer next-state and working-register updates.
  always_comb begin
    state_d   = state_q;
    wbuf_d    = wbuf_q;
    wsrc_d    = wsrc_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    evt_num_d = evt_num_q;
    q_pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!q_empty) begin
          q_pop   = 1'b1;
          wbuf_d  = q_head[SRC_W +: BUF_W];
          wsrc_d  = q_head[0 +: SRC_W];
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_DIG;
      end
      ST_WAIT_DIG: begin
        // Completion takes priority over a timeout in the same cycle.
        if (dig_done_i) begin
          tmo_d   = 1'b0;
          state_d = ST_HEADER;
        end else if (cnt_q + CNT_W'(1) == TIMEOUT_VAL) begin
          tmo_d   = 1'b1;
          state_d = ST_HEADER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HEADER: begin
        if (evt_ready_i) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        evt_num_d = evt_num_q + EVT_NUM_W'(1);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset abandons any event.
  always_ff @(posedge clk250_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      dig_lvl_q <= 1'b0;
      ovf_q     <= 1'b0;
      wbuf_q    <= '0;
      wsrc_q    <= '0;
      tmo_q     <= 1'b0;
      cnt_q     <= '0;
      evt_num_q <= '0;
    end else begin
      state_q   <= state_d;
      dig_lvl_q <= dig_lvl_d;
      ovf_q     <= ovf_d;
      wbuf_q    <= wbuf_d;
      wsrc_q    <= wsrc_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      evt_num_q <= evt_num_d;
    end
  end

  // Outputs decode from state and are forced quiet while reset is held.
  always_comb begin
    dig_start_o    = 1'b0;
    dig_buffer_o   = '0;
    evt_valid_o    = 1'b0;
    evt_header_o   = '0;
    clear_o        = 1'b0;
    clear_buffer_o = '0;
    if (!rst_i) begin
      dig_start_o = (state_q == ST_START);
      if (state_q != ST_IDLE) dig_buffer_o = wbuf_q;
      if (state_q == ST_HEADER) begin
        evt_valid_o  = 1'b1;
        evt_header_o = build_header(evt_num_q, tmo_q, wbuf_q, wsrc_q);
      end
      if (state_q == ST_CLEAR) begin
        clear_o        = 1'b1;
        clear_buffer_o = wbuf_q;
      end
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_anita3_readout_sequencer.sv
// Bench for the ANITA3 readout sequencer: request driver, a digitizer /
// event-builder responder, and a queue model of pending requests.
module tb_anita3_readout_sequencer;

  localparam int TB_TIMEOUT = 64;
  localparam int TB_DEPTH   = 4;

  // ---------------- clock / reset ----------------
  logic        clk250_i = 1'b0;
  logic        rst_i;
  logic        digitize_i;
  logic [1:0]  digitize_buffer_i;
  logic [3:0]  digitize_source_i;
  logic        dig_start_o;
  logic [1:0]  dig_buffer_o;
  logic        dig_done_i;
  logic        evt_valid_o;
  logic        evt_ready_i;
  logic [23:0] evt_header_o;
  logic        clear_o;
  logic [1:0]  clear_buffer_o;
  logic        busy_o;
  logic        overflow_o;

  always #2 clk250_i = ~clk250_i;

  anita3_readout_sequencer #(
    .DIG_TIMEOUT (TB_TIMEOUT),
    .FIFO_DEPTH  (TB_DEPTH)
  ) dut (
    .clk250_i          (clk250_i),
    .rst_i             (rst_i),
    .digitize_i        (digitize_i),
    .digitize_buffer_i (digitize_buffer_i),
    .digitize_source_i (digitize_source_i),
    .dig_start_o       (dig_start_o),
    .dig_buffer_o      (dig_buffer_o),
    .dig_done_i        (dig_done_i),
    .evt_valid_o       (evt_valid_o),
    .evt_ready_i       (evt_ready_i),
    .evt_header_o      (evt_header_o),
    .clear_o           (clear_o),
    .clear_buffer_o    (clear_buffer_o),
    .busy_o            (busy_o),
    .overflow_o        (overflow_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk250_i) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [5:0]  exp_q[$];          // accepted, not yet started: {buf, src}
  logic [15:0] exp_evt_num = '0;
  logic        exp_ovf     = 1'b0;
  int          acc_count   = 0;   // requests the model accepted
  int          start_count = 0;
  int          clr_count   = 0;
  int          last_req_cyc, last_start_cyc, last_clear_cyc;
  bit          aborted;
  bit          rand_mode = 1'b0;
  int          fix_done_delay = 0;   // -1: never complete
  int          fix_ready_delay = 0;

  always @(negedge clk250_i) if (clear_o === 1'b1) clr_count++;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [1:0] b, input logic [3:0] s);
    @(negedge clk250_i);
    digitize_i        = 1'b1;
    digitize_buffer_i = b;
    digitize_source_i = s;
    last_req_cyc      = cyc;
    if (exp_q.size() < TB_DEPTH) begin
      exp_q.push_back({b, s});
      acc_count++;
    end else begin
      exp_ovf = 1'b1;
    end
    @(negedge clk250_i);
    digitize_i = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk250_i);
    #1;
    rst_i = 1'b1;
    exp_q.delete();
    exp_evt_num = '0;
    exp_ovf     = 1'b0;
    @(negedge clk250_i);
    check_eq("rst_dig_start",    32'(dig_start_o),    32'd0);
    check_eq("rst_evt_valid",    32'(evt_valid_o),    32'd0);
    check_eq("rst_clear",        32'(clear_o),        32'd0);
    check_eq("rst_dig_buffer",   32'(dig_buffer_o),   32'd0);
    check_eq("rst_clear_buffer", 32'(clear_buffer_o), 32'd0);
    check_eq("rst_header",       32'(evt_header_o),   32'd0);
    @(negedge clk250_i);
    rst_i = 1'b0;
    @(negedge clk250_i);
    check_eq("post_rst_busy",     32'(busy_o),     32'd0);
    check_eq("post_rst_overflow", 32'(overflow_o), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n     = 0;
    int quiet = 0;
    while (quiet < 4 && n < 3000) begin
      @(negedge clk250_i);
      n++;
      if (!busy_o && exp_q.size() == 0) quiet++;
      else quiet = 0;
    end
    check_eq({tag, "_idle_reached"}, 32'(quiet >= 4), 32'd1);
  endtask

  // ---------------- responder (digitizer + event builder) ----------------
  task automatic step();
    @(negedge clk250_i);
    if (rst_i) aborted = 1'b1;
  endtask

  task automatic quiesce();
    dig_done_i  = 1'b0;
    evt_ready_i = 1'b0;
  endtask

  // Entered at the negedge of the cycle where dig_start_o is seen.
  task automatic service_event();
    logic [5:0]  req;
    logic [1:0]  b;
    logic [3:0]  s;
    logic        tflag;
    logic [23:0] exp_hdr;
    int          dd, rd, wait_cycles;
    last_start_cyc = cyc;
    start_count++;
    if (exp_q.size() == 0) begin
      check_eq("start_without_request", 32'(exp_q.size()), 32'd1);
      return;
    end
    req = exp_q.pop_front();
    b   = req[5:4];
    s   = req[3:0];
    check_eq("start_buffer", 32'(dig_buffer_o), 32'(b));
    if (rand_mode) begin
      dd = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 20));
      rd = $urandom_range(0, 4);
      // A completion pulse while still in START must be ignored.
      if ($urandom_range(0, 1) == 1) dig_done_i = 1'b1;
    end else begin
      dd = fix_done_delay;
      rd = fix_ready_delay;
    end
    tflag       = !(dd >= 0 && dd < TB_TIMEOUT);
    wait_cycles = tflag ? TB_TIMEOUT : dd + 1;
    for (int i = 0; i < wait_cycles; i++) begin
      step();
      if (aborted) begin quiesce(); return; end
      dig_done_i = (dd == i);
      if (i == 0) check_eq("start_pulse_width", 32'(dig_start_o), 32'd0);
      check_eq("wait_no_valid",   32'(evt_valid_o),  32'd0);
      check_eq("wait_dig_buffer", 32'(dig_buffer_o), 32'(b));
    end
    exp_hdr = {exp_evt_num, tflag, 1'b0, b, s};
    for (int j = 0; j <= rd; j++) begin
      step();
      if (aborted) begin quiesce(); return; end
      dig_done_i = 1'b0;
      check_eq("hdr_valid",      32'(evt_valid_o),  32'd1);
      check_eq("hdr_value",      32'(evt_header_o), 32'(exp_hdr));
      check_eq("no_early_clear", 32'(clear_o),      32'd0);
      evt_ready_i = (j == rd);
    end
    step();
    if (aborted) begin quiesce(); return; end
    evt_ready_i    = 1'b0;
    last_clear_cyc = cyc;
    check_eq("clear_pulse",      32'(clear_o),        32'd1);
    check_eq("clear_buffer",     32'(clear_buffer_o), 32'(b));
    check_eq("clear_valid_low",  32'(evt_valid_o),    32'd0);
    exp_evt_num = exp_evt_num + 16'd1;
    step();
    if (aborted) begin quiesce(); return; end
    check_eq("clear_pulse_width", 32'(clear_o), 32'd0);
  endtask

  initial begin : responder
    quiesce();
    forever begin
      @(negedge clk250_i);
      aborted = 1'b0;
      if (!rst_i && dig_start_o === 1'b1) service_event();
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int c0, s0, a0;
    rst_i             = 1'b1;
    digitize_i        = 1'b0;
    digitize_buffer_i = '0;
    digitize_source_i = '0;
    repeat (3) @(negedge clk250_i);
    check_eq("init_dig_start",    32'(dig_start_o),    32'd0);
    check_eq("init_evt_valid",    32'(evt_valid_o),    32'd0);
    check_eq("init_header",       32'(evt_header_o),   32'd0);
    check_eq("init_clear",        32'(clear_o),        32'd0);
    check_eq("init_clear_buffer", 32'(clear_buffer_o), 32'd0);
    check_eq("init_dig_buffer",   32'(dig_buffer_o),   32'd0);
    check_eq("init_busy",         32'(busy_o),         32'd0);
    check_eq("init_overflow",     32'(overflow_o),     32'd0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk250_i);

    // Single request: buffer 2, source 5, done 10 cycles into WAIT_DIG.
    fix_done_delay = 10; fix_ready_delay = 0;
    c0 = clr_count; s0 = start_count;
    send_req(2'd2, 4'h5);
    wait_idle("single");
    check_eq("single_starts", 32'(start_count - s0), 32'd1);
    check_eq("single_clears", 32'(clr_count - c0),   32'd1);

    // Minimum latency with immediate done and ready.
    fix_done_delay = 0; fix_ready_delay = 0;
    send_req(2'd1, 4'h3);
    wait_idle("latency");
    check_eq("latency_start", 32'(last_start_cyc - last_req_cyc), 32'd2);
    check_eq("latency_clear", 32'(last_clear_cyc - last_req_cyc), 32'd5);

    // Four back-to-back requests, serviced in order.
    fix_done_delay = 3; fix_ready_delay = 1;
    c0 = clr_count; a0 = acc_count;
    for (int k = 0; k < 4; k++) send_req(2'(k), 4'($urandom_range(0, 15)));
    wait_idle("burst4");
    check_eq("burst4_clears",   32'(clr_count - c0), 32'(acc_count - a0));
    check_eq("burst4_overflow", 32'(overflow_o),     32'(exp_ovf));

    // One in WAIT_DIG, four queued, one more dropped.
    fix_done_delay = 40; fix_ready_delay = 0;
    c0 = clr_count; a0 = acc_count;
    send_req(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    repeat (4) @(negedge clk250_i);
    for (int k = 0; k < 5; k++) send_req(2'(k), 4'($urandom_range(0, 15)));
    check_eq("ovf_set", 32'(overflow_o), 32'(exp_ovf));
    wait_idle("ovf");
    check_eq("ovf_sticky", 32'(overflow_o),     32'(exp_ovf));
    check_eq("ovf_clears", 32'(clr_count - c0), 32'(acc_count - a0));
    apply_reset();

    // Digitizer never completes: timeout header, clear still issued.
    fix_done_delay = -1; fix_ready_delay = 2;
    c0 = clr_count;
    send_req(2'd3, 4'h9);
    wait_idle("timeout");
    check_eq("timeout_clears", 32'(clr_count - c0), 32'd1);

    // Event builder stalls 20 cycles.
    fix_done_delay = 2; fix_ready_delay = 20;
    send_req(2'd0, 4'hC);
    wait_idle("stall");

    // Reset in WAIT_DIG with two queued: event abandoned, queue flushed.
    fix_done_delay = 50; fix_ready_delay = 0;
    send_req(2'd1, 4'h7);
    repeat (3) @(negedge clk250_i);
    send_req(2'd2, 4'h1);
    send_req(2'd3, 4'h2);
    c0 = clr_count; s0 = start_count;
    apply_reset();
    repeat (10) @(negedge clk250_i);
    check_eq("rst_no_clear", 32'(clr_count - c0),   32'd0);
    check_eq("rst_no_start", 32'(start_count - s0), 32'd0);
    check_eq("rst_idle",     32'(busy_o),           32'd0);
    fix_done_delay = 0;
    send_req(2'd3, 4'hA);
    wait_idle("after_rst");
    check_eq("after_rst_clears", 32'(clr_count - c0), 32'd1);

    // Randomized bursts of up to three requests.
    rand_mode = 1'b1;
    c0 = clr_count; a0 = acc_count;
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        send_req(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        repeat ($urandom_range(0, 3)) @(negedge clk250_i);
      end
      wait_idle("rand");
    end
    check_eq("rand_clears",   32'(clr_count - c0), 32'(acc_count - a0));
    check_eq("rand_overflow", 32'(overflow_o),     32'(exp_ovf));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #400000;
    total++;
    bad++;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
